serial_chunk_adder: RTL and testbench

- Multi-cycle, parametrised successor to the single-bit adder cells. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using a start/busy/done handshake.
- Trades latency for area in datapaths that share one small adder slice across wide operands.
- Produces sum, carry-out and signed overflow.

---
 rtl/serial_chunk_adder_pkg.sv | 16 +
 rtl/adder_chunk.sv | 41 ++++
 rtl/half_adder.sv | 12 +
 rtl/serial_chunk_adder.sv | 143 ++++++++++++++
 tb/tb_serial_chunk_adder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM state encoding and a
// helper that sizes the chunk counter.
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for n chunks; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple slice built from full-adder stages, each
// made of two half_adder cells with the two carries ORed together.
module adder_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_stage
        logic hs;
        logic hc0;
        logic hc1;

        half_adder u_ha0 (
            .a (a[i]),
            .b (b[i]),
            .s (hs),
            .c (hc0)
        );

        half_adder u_ha1 (
            .a (hs),
            .b (carry[i]),
            .s (s[i]),
            .c (hc1)
        );

        assign carry[i+1] = hc0 | hc1;
    end

    assign co = carry[CHUNK];

endmodule

// File: rtl/half_adder.sv
// Gate-level half adder cell: sum and carry of two bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits
// per clock through one shared ripple slice, with a start/busy/done handshake.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             a_msb;
    logic             b_msb;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a  (a_sh[CHUNK-1:0]),
        .b  (b_sh[CHUNK-1:0]),
        .ci (carry_q),
        .s  (s_chunk),
        .co (co_chunk)
    );

    // Chunks enter at the top, so after N steps bit 0 holds the first chunk.
    assign sum_next = WIDTH'({s_chunk, sum_sh} >> CHUNK);
    assign last     = (cnt == CW'(N - 1));

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ST_BUSY);
            done    <= (state_d == ST_DONE);
        end
    end

    // NOTE: the datapath registers are cleared on reset as well, so an aborted
    // operation leaves no stale operands or partial sums behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            a_sh    <= a;
            b_sh    <= b;
            sum_sh  <= '0;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
            carry_q <= cin;
            cnt     <= '0;
        end else if (step) begin
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            sum_sh  <= sum_next;
            carry_q <= co_chunk;
            cnt     <= cnt + CW'(1);
            // Visible results change only when the final chunk lands.
            if (last) begin
                sum  <= sum_next;
                cout <= co_chunk;
                ovf  <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder across four WIDTH/CHUNK
// configurations, with table vectors, handshake corner cases and random ops.
module tb_serial_chunk_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance 0: 8/1, instance 1: 8/2, instance 2: 16/4, instance 3: 8/8
    logic        st0, st1, st2, st3;
    logic [7:0]  a0, b0, a1, b1, a3, b3;
    logic [15:0] a2, b2;
    logic        cin0, cin1, cin2, cin3;
    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic [7:0]  sum0, sum1, sum3;
    logic [15:0] sum2;
    logic        cout0, cout1, cout2, cout3;
    logic        ovf0, ovf1, ovf2, ovf3;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .cin(cin0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n), .start(st3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3));

    int width_of [4] = '{8, 8, 16, 8};
    int n_of     [4] = '{8, 4, 4, 1};

    int errors = 0;
    int checks = 0;
    logic [15:0] last_sum [4];

    typedef struct {
        int          which;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition and sign-bit rule.
    function automatic void ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, output logic [15:0] s,
                                    output logic c, output logic ov);
        longint unsigned mask, ua, ub, t, us;
        bit sa, sb, ss;
        mask = (64'd1 << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        t    = ua + ub + longint'(cin);
        us   = t & mask;
        s    = us[15:0];
        c    = t[w];
        sa   = ua[w-1];
        sb   = ub[w-1];
        ss   = us[w-1];
        ov   = (sa == sb) && (ss != sa);
    endfunction

    task automatic set_in(input int which, input logic st, input logic [15:0] a,
                          input logic [15:0] b, input logic cin);
        case (which)
            0: begin st0 = st; a0 = a[7:0]; b0 = b[7:0]; cin0 = cin; end
            1: begin st1 = st; a1 = a[7:0]; b1 = b[7:0]; cin1 = cin; end
            2: begin st2 = st; a2 = a;      b2 = b;      cin2 = cin; end
            default: begin st3 = st; a3 = a[7:0]; b3 = b[7:0]; cin3 = cin; end
        endcase
    endtask

    task automatic get_out(input int which, output logic bz, output logic dn,
                           output logic [15:0] s, output logic co, output logic ov);
        case (which)
            0: begin bz = busy0; dn = done0; s = {8'h0, sum0}; co = cout0; ov = ovf0; end
            1: begin bz = busy1; dn = done1; s = {8'h0, sum1}; co = cout1; ov = ovf1; end
            2: begin bz = busy2; dn = done2; s = sum2;         co = cout2; ov = ovf2; end
            default: begin bz = busy3; dn = done3; s = {8'h0, sum3}; co = cout3; ov = ovf3; end
        endcase
    endtask

    // Called at a negedge with the instance idle; checks exact latency,
    // held outputs during BUSY, the result, and a single done pulse.
    task automatic run_op(input string name, input int which, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic [15:0] es,
                          input logic ec, input logic eo);
        logic bz, dn, co, ov;
        logic [15:0] s;
        set_in(which, 1'b1, a, b, cin);
        @(negedge clk);
        set_in(which, 1'b0, ~a, ~b, ~cin);
        for (int i = 0; i < n_of[which]; i++) begin
            get_out(which, bz, dn, s, co, ov);
            check($sformatf("%s busy[%0d]", name, i), {bz, dn}, 2'b10);
            check($sformatf("%s held sum[%0d]", name, i), s, last_sum[which]);
            @(negedge clk);
        end
        get_out(which, bz, dn, s, co, ov);
        check({name, " done"}, {bz, dn}, 2'b01);
        check({name, " sum"}, s, es);
        check({name, " cout/ovf"}, {co, ov}, {ec, eo});
        last_sum[which] = es;
        @(negedge clk);
        get_out(which, bz, dn, s, co, ov);
        check({name, " idle after done"}, {bz, dn}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic bz, dn, co, ov;
        logic [15:0] s, ra, rb, es;
        logic rc, ec, eo;
        int dcount;

        vecs[0] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
        vecs[2] = '{1, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{2, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{3, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0};
        vecs[5] = '{2, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};

        for (int w = 0; w < 4; w++) begin
            set_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
            last_sum[w] = 16'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 4; w++) begin
            get_out(w, bz, dn, s, co, ov);
            check($sformatf("reset inst%0d", w), {bz, dn, s, co, ov}, 20'h0);
        end

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].which, vecs[i].a, vecs[i].b,
                   vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // start pulsed again during BUSY must be ignored
        set_in(0, 1'b1, 16'd3, 16'd4, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 16'd3, 16'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        set_in(0, 1'b1, 16'd100, 16'd4, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 16'd100, 16'd4, 1'b0);
        dcount = 0;
        s = 16'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0) begin
                dcount++;
                s = {8'h0, sum0};
            end
        end
        check("ignore-start done count", dcount, 1);
        check("ignore-start sum", s, 16'd7);
        last_sum[0] = 16'd7;

        // back-to-back with start held high, CHUNK == WIDTH
        begin
            logic [7:0] pa [3] = '{8'd1, 8'd10, 8'd200};
            logic [7:0] pb [3] = '{8'd2, 8'd20, 8'd100};
            logic [7:0] ps [3] = '{8'd3, 8'd30, 8'd44};
            logic       pc [3] = '{1'b0, 1'b0, 1'b1};
            for (int p = 0; p < 3; p++) begin
                set_in(3, 1'b1, {8'h0, pa[p]}, {8'h0, pb[p]}, 1'b0);
                @(negedge clk);
                check($sformatf("b2b%0d busy", p), {busy3, done3}, 2'b10);
                @(negedge clk);
                check($sformatf("b2b%0d done", p), {busy3, done3}, 2'b01);
                check($sformatf("b2b%0d sum/cout", p), {sum3, cout3}, {ps[p], pc[p]});
            end
            set_in(3, 1'b0, 16'h0, 16'h0, 1'b0);
            @(negedge clk);
            check("b2b idle", {busy3, done3}, 2'b00);
            last_sum[3] = 16'd44;
        end

        // reset in the middle of an operation
        set_in(0, 1'b1, 16'h00AA, 16'h0055, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 16'h00AA, 16'h0055, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort outputs cleared", {busy0, done0, sum0, cout0, ovf0}, 12'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0 || busy0) dcount++;
        end
        check("abort no done", dcount, 0);
        for (int w = 0; w < 4; w++) last_sum[w] = 16'h0;
        run_op("after-abort", 0, 16'd5, 16'd6, 1'b0, 16'd11, 1'b0, 1'b0);

        // randomized operations against the arithmetic reference
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 10; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom_range(0, 1));
                if (width_of[w] == 8) begin
                    ra[15:8] = 8'h0;
                    rb[15:8] = 8'h0;
                end
                ref_add(width_of[w], ra, rb, rc, es, ec, eo);
                run_op($sformatf("rand%0d_%0d", w, k), w, ra, rb, rc, es, ec, eo);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
